pll_lock_supervisor: RTL and testbench

Reset and lock supervisor for the board PLL. It runs on the free-running 27 MHz reference clock, so it keeps working while the PLL output is absent.
- Drives the PLL reset input and watches its asynchronous `locked` output.
- Re-resets the PLL on lock timeout or lock loss.
- Releases a system reset only after lock has been stable for a programmable time.
- Downstream domains bring `sys_rst` into their own clock with their own synchronizers.

---
 rtl/pll_sup_pkg.sv | 15 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 101 ++++++++++
 tb/tb_pll_lock_supervisor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encoding and 27 MHz default timings for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES      = 27;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 27000;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 2700000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer, async active-high reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - drives PLL reset, watches lock, releases sys_rst after stable lock
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int          CNT_W               = 22,
    parameter int          LOSS_CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [LOSS_CNT_W-1:0] timeout_count
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] EVT_ONE = LOSS_CNT_W'(1);

    logic             locked_s;
    pll_state_t       state_q;
    pll_state_t       state_d;
    logic [CNT_W-1:0] cnt;
    logic             timeout_evt;
    logic             loss_evt;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Lock beats timeout in WAIT_LOCK; lock drop beats completion in STABILIZE.
    always_comb begin
        state_d     = state_q;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (cnt == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_d     = RESET_PLL;
                    timeout_evt = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s)                state_d = WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_d  = RESET_PLL;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = RESET_PLL;
        endcase
    end

    // Outputs are decoded from next-state so they move on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt     <= (state_d != state_q) ? '0 : cnt + CNT_ONE;
            pll_rst <= (state_d == RESET_PLL);
            sys_rst <= (state_d != RUN);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            timeout_count   <= '0;
            lock_loss_count <= '0;
        end else begin
            if (timeout_evt && (timeout_count != '1))
                timeout_count <= timeout_count + EVT_ONE;
            if (loss_evt && (lock_loss_count != '1))
                lock_loss_count <= lock_loss_count + EVT_ONE;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor with a phase/duration reference model
module tb_pll_lock_supervisor;

    localparam int P_RST   = 4;
    localparam int P_STAB  = 8;
    localparam int P_TOUT  = 32;
    localparam int EVT_MAX = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic [1:0] state;
    logic [1:0] lock_loss_count;
    logic [1:0] timeout_count;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT_CYCLES (P_TOUT),
        .CNT_W               (6),
        .LOSS_CNT_W          (2)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .state           (state),
        .lock_loss_count (lock_loss_count),
        .timeout_count   (timeout_count)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int st;
        int prst;
        int srst;
        int lc;
        int tc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0..3, edges spent in phase, lock history as seen two edges late.
    int m_phase, m_elapsed, m_lc, m_tc;
    bit m_h1, m_h2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_lc = 0; m_tc = 0;
        m_h1 = 1'b0; m_h2 = 1'b0;
    endtask

    task automatic go(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endtask

    task automatic model_edge(input bit v);
        bit   seen;
        exp_t e;
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = v;
        m_elapsed++;
        case (m_phase)
            0: if (m_elapsed == P_RST) go(1);
            1: if (seen) go(2);
               else if (m_elapsed == P_TOUT) begin
                   go(0);
                   if (m_tc < EVT_MAX) m_tc++;
               end
            2: if (!seen) go(1);
               else if (m_elapsed == P_STAB) go(3);
            default: if (!seen) begin
                   go(0);
                   if (m_lc < EVT_MAX) m_lc++;
               end
        endcase
        e.st   = m_phase;
        e.prst = (m_phase == 0) ? 1 : 0;
        e.srst = (m_phase == 3) ? 0 : 1;
        e.lc   = m_lc;
        e.tc   = m_tc;
        exp_q.push_back(e);
    endtask

    // Drives one level per cycle at the falling edge; the model predicts the next rising edge.
    task automatic run_seg(input bit v, input int n);
        repeat (n) begin
            pll_locked = v;
            model_edge(v);
            @(negedge refclk);
        end
    endtask

    always @(posedge refclk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",           int'(state),           e.st);
            chk("pll_rst",         int'(pll_rst),         e.prst);
            chk("sys_rst",         int'(sys_rst),         e.srst);
            chk("lock_loss_count", int'(lock_loss_count), e.lc);
            chk("timeout_count",   int'(timeout_count),   e.tc);
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"},   int'(state),           0);
        chk({tag, "_pll_rst"}, int'(pll_rst),         1);
        chk({tag, "_sys_rst"}, int'(sys_rst),         1);
        chk({tag, "_loss"},    int'(lock_loss_count), 0);
        chk({tag, "_tout"},    int'(timeout_count),   0);
    endtask

    initial begin
        int guard;
        rst        = 1'b1;
        pll_locked = 1'b0;
        model_reset();
        @(negedge refclk);
        @(negedge refclk);
        chk_reset_values("reset");
        rst = 1'b0;

        // Timeout, lock-up to RUN, then five losses to saturate the loss counter.
        run_seg(1'b0, 45);
        run_seg(1'b1, 25);
        repeat (5) begin
            run_seg(1'b0, 3);
            run_seg(1'b1, 25);
        end

        // Lock drop for 3 cycles at STABILIZE count 5, then relock.
        run_seg(1'b0, 8);
        run_seg(1'b1, 5);
        run_seg(1'b0, 3);
        run_seg(1'b1, 20);

        // Async reset between edges while in STABILIZE with nonzero event counters.
        run_seg(1'b0, 6);
        guard = 0;
        while (!(m_phase == 2 && m_elapsed == 3) && guard < 200) begin
            run_seg(1'b1, 1);
            guard++;
        end
        chk("reach_stabilize", guard < 200 ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        @(negedge refclk);
        chk_reset_values("async_rst_hold");
        rst = 1'b0;
        model_reset();

        repeat (120) begin
            if ($urandom_range(0, 1) == 1)
                run_seg(1'b1, int'($urandom_range(1, 40)));
            else
                run_seg(1'b0, int'($urandom_range(1, 45)));
        end

        @(negedge refclk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
